// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin arbitrated up/down counter with burst lock
// Optional CNT_ARB_SAT_EN: saturating arithmetic instead of modulo wrap.
module counter_arbiter #(
   parameter int               WIDTH   = 8,
   parameter int               NREQ    = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  dec,
   input  logic [NREQ-1:0]  lock,
   output logic [WIDTH-1:0] out,
   output logic [NREQ-1:0]  gnt,
   output logic             zero,
   output logic             wrap
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   ptr;

   logic            found_hi;
   logic            found_lo;
   logic [PW-1:0]   win_hi;
   logic [PW-1:0]   win_lo;
   logic [PW-1:0]   win;
   logic            owner_req;
   logic [PW-1:0]   sel;
   logic            sel_dec;
   logic            sel_lock;
   logic            grant_valid;
   logic [PW-1:0]   ptr_nxt;
   logic [WIDTH-1:0] nxt_out;
   logic            nxt_wrap;

   // Round-robin search: lowest set request at or above ptr, else lowest overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            if (!found_lo) begin
               found_lo = 1'b1;
               win_lo   = PW'(i);
            end
            if (!found_hi && (PW'(i) >= ptr)) begin
               found_hi = 1'b1;
               win_hi   = PW'(i);
            end
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == owner) begin
            owner_req = req[i];
         end
      end
   end

   assign sel = (state == LOCKED) ? owner : win;

   always_comb begin
      sel_dec  = 1'b0;
      sel_lock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == sel) begin
            sel_dec  = dec[i];
            sel_lock = lock[i];
         end
      end
   end

   assign grant_valid = !reset && enable &&
                        ((state == LOCKED) ? owner_req : found_lo);

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = grant_valid && (sel == PW'(i));
      end
   end

   assign ptr_nxt = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);

`ifdef CNT_ARB_SAT_EN
   always_comb begin
      nxt_wrap = 1'b0;
      if (sel_dec) begin
         nxt_out = (out == '0) ? out : out - WIDTH'(1);
      end else begin
         nxt_out = (out == '1) ? out : out + WIDTH'(1);
      end
   end
`else
   always_comb begin
      if (sel_dec) begin
         nxt_out  = out - WIDTH'(1);
         nxt_wrap = (out == '0);
      end else begin
         nxt_out  = out + WIDTH'(1);
         nxt_wrap = (out == '1);
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out   <= RST_VAL;
         wrap  <= 1'b0;
         state <= ARB;
         owner <= '0;
         ptr   <= '0;
      end else begin
         wrap <= 1'b0;
         if (enable) begin
            if (grant_valid) begin
               out  <= nxt_out;
               wrap <= nxt_wrap;
               ptr  <= ptr_nxt;
            end
            case (state)
               ARB: begin
                  if (grant_valid && sel_lock) begin
                     state <= LOCKED;
                     owner <= sel;
                  end
               end
               LOCKED: begin
                  // A missing owner request or a lock=0 operation ends the burst.
                  if (!owner_req || !sel_lock) begin
                     state <= ARB;
                  end
               end
               default: state <= ARB;
            endcase
         end
      end
   end

   assign zero = (out == '0);

endmodule
